// File: rtl/svpwm_timing.sv
// Space-vector PWM timing stage: turns the three inverse-Clarke reference
// voltages into a sector number and three centre-aligned compare values.
// When the requested dwell times exceed the period, they are rescaled with a
// 16-cycle restoring divider so that the vector stays on the hexagon boundary.
module svpwm_timing #(
  parameter int PWM_PERIOD = 2500,
  parameter int K_GAIN     = 4096
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iSV_en,
  input  logic [15:0] iV1,
  input  logic [15:0] iV2,
  input  logic [15:0] iV3,
  output logic [15:0] oTcm1,
  output logic [15:0] oTcm2,
  output logic [15:0] oTcm3,
  output logic [2:0]  oSector,
  output logic        oSV_done,
  output logic        oBusy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_XYZ  = 3'd1;
  localparam logic [2:0] S_SEL  = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_TIME = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  localparam logic signed [32:0] K_S    = 33'(K_GAIN);
  localparam logic [14:0]        PER_15 = 15'(PWM_PERIOD);
  localparam logic [15:0]        PER_16 = 16'(PWM_PERIOD);
  localparam logic [18:0]        PER_19 = 19'(PWM_PERIOD);
  localparam logic [19:0]        PER_20 = 20'(PWM_PERIOD);

  logic [2:0]         state;
  logic               en_q;
  logic signed [15:0] v1_q, v2_q, v3_q;
  logic signed [17:0] x_q, y_q, z_q;
  logic [2:0]         n_q;
  logic [17:0]        t1_q, t2_q;
  logic [33:0]        rem_q, dvs_q;
  logic [14:0]        quo_q;
  logic [3:0]         cnt_q;
  logic [15:0]        ta_q, tb_q, tc_q;

  // Scale by k in Q12 and clamp into the 18-bit signed working range.
  function automatic logic signed [17:0] sat18(input logic signed [32:0] p);
    if ((p >>> 12) > 33'sd131071)       sat18 = 18'sh1ffff;
    else if ((p >>> 12) < -33'sd131072) sat18 = 18'sh20000;
    else                                sat18 = 18'(p >>> 12);
  endfunction

  logic signed [32:0] v1_e, v2_e, v3_e;
  logic signed [32:0] px, py, pz;
  logic [2:0]         n_c;
  logic signed [18:0] xe, ye, ze, t1s, t2s;
  logic [17:0]        t1c, t2c;
  logic [18:0]        s_c;
  logic               ge;
  logic [33:0]        rem_n;
  logic [15:0]        quo_n;
  logic [15:0]        ta_c, tb_c, tc_c;

  // Combinational datapath for every FSM stage; each stage's registers pick
  // up the slice they need.
  always_comb begin
    v1_e = {{17{v1_q[15]}}, v1_q};
    v2_e = {{17{v2_q[15]}}, v2_q};
    v3_e = {{17{v3_q[15]}}, v3_q};
    px   = v1_e * K_S;
    py   = -v3_e * K_S;
    pz   = -v2_e * K_S;
    n_c  = {v3_q > 16'sd0, v2_q > 16'sd0, v1_q > 16'sd0};

    xe = {x_q[17], x_q};
    ye = {y_q[17], y_q};
    ze = {z_q[17], z_q};
    case (n_q)
      3'd1:    begin t1s = ze;  t2s = ye;  end
      3'd2:    begin t1s = ye;  t2s = -xe; end
      3'd3:    begin t1s = -ze; t2s = xe;  end
      3'd4:    begin t1s = -xe; t2s = ze;  end
      3'd5:    begin t1s = xe;  t2s = -ye; end
      3'd6:    begin t1s = -ye; t2s = -ze; end
      default: begin t1s = '0;  t2s = '0;  end
    endcase
    t1c = t1s[18] ? 18'd0 : t1s[17:0];
    t2c = t2s[18] ? 18'd0 : t2s[17:0];
    s_c = {1'b0, t1c} + {1'b0, t2c};

    // One restoring step: divisor is pre-shifted left by 15 and walks right.
    ge    = rem_q >= dvs_q;
    rem_n = ge ? (rem_q - dvs_q) : rem_q;
    quo_n = {quo_q, ge};

    ta_c = 16'((PER_20 - {2'b0, t1_q} - {2'b0, t2_q}) >> 2);
    tb_c = ta_c + 16'(t1_q >> 1);
    tc_c = tb_c + 16'(t2_q >> 1);
  end

  // Start-edge history; updates every cycle regardless of busy.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) en_q <= 1'b0;
    else         en_q <= iSV_en;
  end

  // Sequencer: latch, XYZ, T1/T2 select, optional rescale, timing, output.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= S_IDLE;
      v1_q     <= '0;
      v2_q     <= '0;
      v3_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      n_q      <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      ta_q     <= '0;
      tb_q     <= '0;
      tc_q     <= '0;
      oTcm1    <= '0;
      oTcm2    <= '0;
      oTcm3    <= '0;
      oSector  <= '0;
      oSV_done <= 1'b0;
      oBusy    <= 1'b0;
    end else begin
      oSV_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iSV_en && !en_q) begin
            v1_q  <= iV1;
            v2_q  <= iV2;
            v3_q  <= iV3;
            oBusy <= 1'b1;
            state <= S_XYZ;
          end
        end
        S_XYZ: begin
          x_q   <= sat18(px);
          y_q   <= sat18(py);
          z_q   <= sat18(pz);
          n_q   <= n_c;
          state <= S_SEL;
        end
        S_SEL: begin
          t1_q  <= t1c;
          t2_q  <= t2c;
          rem_q <= {16'd0, t1c} * {19'd0, PER_15};
          dvs_q <= {s_c, 15'd0};
          quo_q <= '0;
          cnt_q <= '0;
          state <= (s_c > PER_19) ? S_DIV : S_TIME;
        end
        S_DIV: begin
          rem_q <= rem_n;
          dvs_q <= dvs_q >> 1;
          quo_q <= quo_n[14:0];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            t1_q  <= {2'b0, quo_n};
            t2_q  <= {2'b0, PER_16 - quo_n};
            state <= S_TIME;
          end
        end
        S_TIME: begin
          ta_q  <= ta_c;
          tb_q  <= tb_c;
          tc_q  <= tc_c;
          state <= S_OUT;
        end
        S_OUT: begin
          case (n_q)
            3'd1:    begin oTcm1 <= tb_q; oTcm2 <= ta_q; oTcm3 <= tc_q; end
            3'd2:    begin oTcm1 <= ta_q; oTcm2 <= tc_q; oTcm3 <= tb_q; end
            3'd3:    begin oTcm1 <= ta_q; oTcm2 <= tb_q; oTcm3 <= tc_q; end
            3'd4:    begin oTcm1 <= tc_q; oTcm2 <= tb_q; oTcm3 <= ta_q; end
            3'd5:    begin oTcm1 <= tc_q; oTcm2 <= ta_q; oTcm3 <= tb_q; end
            3'd6:    begin oTcm1 <= tb_q; oTcm2 <= tc_q; oTcm3 <= ta_q; end
            default: begin oTcm1 <= ta_q; oTcm2 <= ta_q; oTcm3 <= ta_q; end
          endcase
          oSector  <= (n_q == 3'd7) ? 3'd0 : n_q;
          oSV_done <= 1'b1;
          oBusy    <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svpwm_timing.sv
// Directed + randomized bench for svpwm_timing against an integer model.
module tb_svpwm_timing;
  localparam int P = 2500;
  localparam int K = 4096;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iSV_en = 1'b0;
  logic [15:0] iV1 = '0, iV2 = '0, iV3 = '0;
  logic [15:0] oTcm1, oTcm2, oTcm3;
  logic [2:0]  oSector;
  logic        oSV_done, oBusy;

  int checks = 0;
  int errors = 0;
  int c_t1, c_t2, c_t3, c_sec;

  svpwm_timing #(.PWM_PERIOD(P), .K_GAIN(K)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iSV_en(iSV_en),
    .iV1(iV1), .iV2(iV2), .iV3(iV3),
    .oTcm1(oTcm1), .oTcm2(oTcm2), .oTcm3(oTcm3),
    .oSector(oSector), .oSV_done(oSV_done), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  // Reference: plain integer arithmetic on the sector / dwell-time rules.
  task automatic model(input int v1, input int v2, input int v3,
                       output int sec, output int e1, output int e2, output int e3,
                       output int de);
    longint x, y, z, t1, t2, s, ta, tb, tc;
    int n;
    x = sat((longint'(v1) * K) >>> 12);
    y = sat((-longint'(v3) * K) >>> 12);
    z = sat((-longint'(v2) * K) >>> 12);
    n = (v1 > 0 ? 1 : 0) + (v2 > 0 ? 2 : 0) + (v3 > 0 ? 4 : 0);
    case (n)
      1: begin t1 = z;  t2 = y;  end
      2: begin t1 = y;  t2 = -x; end
      3: begin t1 = -z; t2 = x;  end
      4: begin t1 = -x; t2 = z;  end
      5: begin t1 = x;  t2 = -y; end
      6: begin t1 = -y; t2 = -z; end
      default: begin t1 = 0; t2 = 0; end
    endcase
    if (t1 < 0) t1 = 0;
    if (t2 < 0) t2 = 0;
    s = t1 + t2;
    de = 4;
    if (s > P) begin
      t1 = (t1 * P) / s;
      t2 = P - t1;
      de = 20;
    end
    ta = (P - t1 - t2) / 4;
    tb = ta + t1 / 2;
    tc = tb + t2 / 2;
    case (n)
      1: begin e1 = int'(tb); e2 = int'(ta); e3 = int'(tc); end
      2: begin e1 = int'(ta); e2 = int'(tc); e3 = int'(tb); end
      3: begin e1 = int'(ta); e2 = int'(tb); e3 = int'(tc); end
      4: begin e1 = int'(tc); e2 = int'(tb); e3 = int'(ta); end
      5: begin e1 = int'(tc); e2 = int'(ta); e3 = int'(tb); end
      6: begin e1 = int'(tb); e2 = int'(tc); e3 = int'(ta); end
      default: begin e1 = int'(ta); e2 = int'(ta); e3 = int'(ta); end
    endcase
    e1 &= 16'hffff; e2 &= 16'hffff; e3 &= 16'hffff;
    sec = (n == 7) ? 0 : n;
  endtask

  // iSV_en level presented at edge e. 0: single pulse; 1: long hold with a
  // second rising edge while busy; 2: extra rising edge on the done edge.
  function automatic logic en_at(input int mode, input int e, input int de);
    case (mode)
      1:       return (e < 10) && (e != 2);
      2:       return (e == 0) || (e == de);
      default: return e == 0;
    endcase
  endfunction

  task automatic run(input int v1, input int v2, input int v3, input int mode, input string tag);
    int sec, e1, e2, e3, de, ndone;
    model(v1, v2, v3, sec, e1, e2, e3, de);
    c_t1 = -1; c_t2 = -1; c_t3 = -1; c_sec = -1;
    ndone = 0;
    @(negedge iClk);
    iV1 = 16'(v1); iV2 = 16'(v2); iV3 = 16'(v3);
    iSV_en = en_at(mode, 0, de);
    for (int e = 0; e <= de + 6; e++) begin
      @(negedge iClk);
      if (e == 0) begin
        iV1 = 16'($urandom); iV2 = 16'($urandom); iV3 = 16'($urandom);
      end
      chk({tag, ":busy"}, 32'(oBusy), 32'(e < de));
      chk({tag, ":done"}, 32'(oSV_done), 32'(e == de));
      if (oSV_done) begin
        ndone++;
        c_t1 = int'(oTcm1); c_t2 = int'(oTcm2); c_t3 = int'(oTcm3); c_sec = int'(oSector);
      end
      iSV_en = en_at(mode, e + 1, de);
    end
    chk({tag, ":ndone"}, 32'(ndone), 32'd1);
    chk({tag, ":sector"}, 32'(c_sec), 32'(sec));
    chk({tag, ":tcm1"}, 32'(c_t1), 32'(e1));
    chk({tag, ":tcm2"}, 32'(c_t2), 32'(e2));
    chk({tag, ":tcm3"}, 32'(c_t3), 32'(e3));
    chk({tag, ":hold1"}, 32'(oTcm1), 32'(e1));
    iSV_en = 1'b0;
    @(negedge iClk);
  endtask

  initial begin
    int r1, r2, r3, sel;
    #1;
    chk("rst:tcm1", 32'(oTcm1), 0);
    chk("rst:tcm2", 32'(oTcm2), 0);
    chk("rst:tcm3", 32'(oTcm3), 0);
    chk("rst:sector", 32'(oSector), 0);
    chk("rst:done", 32'(oSV_done), 0);
    chk("rst:busy", 32'(oBusy), 0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;

    run(0, 0, 0, 0, "zero");
    chk("zero:c", 32'(c_t1), 625);
    chk("zero:c3", 32'(c_t3), 625);
    run(400, -100, -300, 0, "sec1");
    chk("sec1:c1", 32'(c_t1), 575);
    chk("sec1:c2", 32'(c_t2), 525);
    chk("sec1:c3", 32'(c_t3), 725);
    run(3000, -1000, -2000, 0, "ovm");
    chk("ovm:c1", 32'(c_t1), 416);
    chk("ovm:c2", 32'(c_t2), 0);
    chk("ovm:c3", 32'(c_t3), 1249);
    run(-300, 500, -200, 0, "sec2");
    chk("sec2:n", 32'(c_sec), 2);
    run(400, 300, -700, 0, "sec3");
    chk("sec3:c1", 32'(c_t1), 450);
    chk("sec3:c2", 32'(c_t2), 600);
    chk("sec3:c3", 32'(c_t3), 800);
    run(-300, -200, 500, 0, "sec4");
    chk("sec4:n", 32'(c_sec), 4);
    run(300, -500, 200, 0, "sec5");
    chk("sec5:n", 32'(c_sec), 5);
    run(-300, 200, 100, 0, "sec6");
    chk("sec6:n", 32'(c_sec), 6);
    run(100, 100, 100, 0, "sec7");
    run(2500, -1000, -1500, 0, "s_eq_p");
    chk("s_eq_p:c3", 32'(c_t3), 1250);
    run(2500, -1000, -1501, 0, "s_gt_p");

    run(400, -100, -300, 1, "hold");
    run(-300, 500, -200, 0, "after_hold");
    run(400, 300, -700, 2, "out_edge");

    // Reset in the middle of the divider phase.
    @(negedge iClk);
    iV1 = 16'(3000); iV2 = 16'(-1000); iV3 = 16'(-2000);
    iSV_en = 1'b1;
    @(negedge iClk);
    iSV_en = 1'b0;
    repeat (9) @(negedge iClk);
    @(posedge iClk);
    #2 iRst_n = 1'b0;
    #1;
    chk("mrst:tcm1", 32'(oTcm1), 0);
    chk("mrst:tcm2", 32'(oTcm2), 0);
    chk("mrst:tcm3", 32'(oTcm3), 0);
    chk("mrst:sector", 32'(oSector), 0);
    chk("mrst:busy", 32'(oBusy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      chk("mrst:done", 32'(oSV_done), 0);
    end
    iRst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge iClk);
      chk("mrst:nodone", 32'(oSV_done), 0);
    end
    run(3000, -1000, -2000, 0, "post_rst");

    for (int i = 0; i < 20; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        r1 = int'($urandom_range(0, 1600)) - 800;
        r2 = int'($urandom_range(0, 1600)) - 800;
        r3 = int'($urandom_range(0, 1600)) - 800;
      end else if (sel == 1) begin
        r1 = int'($urandom_range(0, 6000)) - 3000;
        r2 = int'($urandom_range(0, 6000)) - 3000;
        r3 = int'($urandom_range(0, 6000)) - 3000;
      end else begin
        r1 = int'($signed(16'($urandom)));
        r2 = int'($signed(16'($urandom)));
        r3 = int'($signed(16'($urandom)));
      end
      run(r1, r2, r3, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
